// File: rtl/hb_boot_pkg.sv
// Shared types for the boot copy sequencer: state encoding and per-state strobe table.
package hb_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCRd,
    StCWr,
    StCHold,
    StVRom,
    StVRam,
    StDone,
    StError
  } state_e;

  typedef struct packed {
    logic rom_ce_bar;
    logic rom_oe_bar;
    logic ram_ce_bar;
    logic ram_we_bar;
    logic data_oe;
    logic busy;
    logic done;
    logic error;
  } strobe_t;

  localparam strobe_t StrbIdle = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // Bus and status pins for each state; ROM strobes and data_oe are never both active.
  function automatic strobe_t strobe_tbl(state_e st);
    strobe_t s;
    s = StrbIdle;
    unique case (st)
      StIdle:  s = StrbIdle;
      StCRd:   s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      StCWr:   s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      StCHold: s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      StVRom:  s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      StVRam:  s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      StDone:  s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      StError: s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      default: s = StrbIdle;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/addr_ctr12.sv
// 12-bit address counter with synchronous clear, increment and terminal compare.
module addr_ctr12 #(
  parameter logic [11:0] LastAddr = 12'hFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [11:0] addr_o,
  output logic        last_o
);

  logic [11:0] addr_q, addr_d;

  // Clear wins over increment; increment is never requested at the terminal address.
  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = 12'h000;
    end else if (inc_i) begin
      addr_d = addr_q + 12'h001;
    end
  end

  // Address register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= 12'h000;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == LastAddr);

endmodule

// File: rtl/boot_copy_seq.sv
// Boot copy sequencer: copies program store to RAM byte by byte, optionally verifies it.
import hb_boot_pkg::*;

module boot_copy_seq #(
  parameter logic [11:0] LAST_ADDR = 12'hFFF,
  parameter int unsigned WE_PULSE  = 1,  // write strobe width, 1..4 cycles
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_bar,
  input  logic        start,
  output logic [11:0] addr,
  output logic        rom_ce_bar,
  output logic        rom_oe_bar,
  output logic        ram_ce_bar,
  output logic        ram_we_bar,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] err_addr
);

  localparam logic [1:0] WeLast = 2'(WE_PULSE - 1);

  state_e      state_q, state_d;
  strobe_t     strb_q;
  logic [1:0]  we_cnt_q, we_cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [7:0]  cmp_q, cmp_d;
  logic [11:0] err_addr_q, err_addr_d;
  logic        ctr_clr, ctr_inc, ctr_last;

  addr_ctr12 #(
    .LastAddr(LAST_ADDR)
  ) u_addr_ctr12 (
    .clk_i (clk),
    .rst_ni(rst_bar),
    .clr_i (ctr_clr),
    .inc_i (ctr_inc),
    .addr_o(addr),
    .last_o(ctr_last)
  );

  // Next-state, address counter control and data/compare latching.
  always_comb begin
    state_d    = state_q;
    we_cnt_d   = we_cnt_q;
    data_out_d = data_out_q;
    cmp_d      = cmp_q;
    err_addr_d = err_addr_q;
    ctr_clr    = 1'b0;
    ctr_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ctr_clr = 1'b1;
          state_d = StCRd;
        end
      end
      StCRd: begin
        data_out_d = data_in;
        we_cnt_d   = 2'd0;
        state_d    = StCWr;
      end
      StCWr: begin
        if (we_cnt_q == WeLast) begin
          state_d = StCHold;
        end else begin
          we_cnt_d = we_cnt_q + 2'd1;
        end
      end
      StCHold: begin
        if (!ctr_last) begin
          ctr_inc = 1'b1;
          state_d = StCRd;
        end else begin
          ctr_clr = 1'b1;
          state_d = VERIFY_EN ? StVRom : StDone;
        end
      end
      StVRom: begin
        cmp_d   = data_in;
        state_d = StVRam;
      end
      StVRam: begin
        if (data_in != cmp_q) begin
          err_addr_d = addr;
          state_d    = StError;
        end else if (ctr_last) begin
          state_d = StDone;
        end else begin
          ctr_inc = 1'b1;
          state_d = StVRom;
        end
      end
      StDone, StError: ;  // terminal until reset
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered strobes; the strobe table is looked up from the next state.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q    <= StIdle;
      strb_q     <= StrbIdle;
      we_cnt_q   <= 2'd0;
      data_out_q <= 8'h00;
      cmp_q      <= 8'h00;
      err_addr_q <= 12'h000;
    end else begin
      state_q    <= state_d;
      strb_q     <= strobe_tbl(state_d);
      we_cnt_q   <= we_cnt_d;
      data_out_q <= data_out_d;
      cmp_q      <= cmp_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign rom_ce_bar = strb_q.rom_ce_bar;
  assign rom_oe_bar = strb_q.rom_oe_bar;
  assign ram_ce_bar = strb_q.ram_ce_bar;
  assign ram_we_bar = strb_q.ram_we_bar;
  assign data_oe    = strb_q.data_oe;
  assign busy       = strb_q.busy;
  assign done       = strb_q.done;
  assign error      = strb_q.error;
  assign data_out   = data_out_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_boot_copy_seq.sv
// Scoreboard bench for boot_copy_seq: three parameterisations share a clock and reset.
module tb_boot_copy_seq;

  localparam int NI = 3;
  localparam int unsigned WEP [NI] = '{1, 1, 3};
  localparam bit          VEN [NI] = '{1'b0, 1'b1, 1'b1};

  // kind: 0 write start, 1 done rise, 2 error rise
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  inst;
    logic [11:0] addr;
    logic [7:0]  data;
    logic [15:0] cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_bar = 1'b1;
  logic [NI-1:0] start = '0;
  logic          stuck = 1'b0;

  logic [11:0] addr_w     [NI];
  logic        rom_ce_bar [NI];
  logic        rom_oe_bar [NI];
  logic        ram_ce_bar [NI];
  logic        ram_we_bar [NI];
  logic [7:0]  data_in    [NI];
  logic [7:0]  dout       [NI];
  logic        data_oe    [NI];
  logic        busy       [NI];
  logic        done       [NI];
  logic        error      [NI];
  logic [11:0] err_addr   [NI];

  logic [7:0] ram [NI][16];
  int         start_n [NI];
  ev_t        exp_q [$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    boot_copy_seq #(
      .LAST_ADDR(12'd15),
      .WE_PULSE (WEP[k]),
      .VERIFY_EN(VEN[k])
    ) u_dut (
      .clk       (clk),
      .rst_bar   (rst_bar),
      .start     (start[k]),
      .addr      (addr_w[k]),
      .rom_ce_bar(rom_ce_bar[k]),
      .rom_oe_bar(rom_oe_bar[k]),
      .ram_ce_bar(ram_ce_bar[k]),
      .ram_we_bar(ram_we_bar[k]),
      .data_in   (data_in[k]),
      .data_out  (dout[k]),
      .data_oe   (data_oe[k]),
      .busy      (busy[k]),
      .done      (done[k]),
      .error     (error[k]),
      .err_addr  (err_addr[k])
    );
    // ROM image is addr^A5; instance 1 can model RAM bit 0 of address 7 stuck at 1.
    assign data_in[k] =
        (!rom_ce_bar[k] && !rom_oe_bar[k]) ? (addr_w[k][7:0] ^ 8'hA5) :
        (!ram_ce_bar[k] && ram_we_bar[k] && !data_oe[k]) ?
            (ram[k][addr_w[k][3:0]] |
             ((stuck && k == 1 && addr_w[k] == 12'd7) ? 8'h01 : 8'h00)) :
        8'h00;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int inst, input int a, input int d,
                         input int cyc);
    ev_t e;
    e.kind = 2'(kind);
    e.inst = 2'(inst);
    e.addr = 12'(a);
    e.data = 8'(d);
    e.cyc  = 16'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic push_copy(input int inst, input int nbytes);
    for (int i = 0; i < nbytes; i++) push_ev(0, inst, i, i ^ 'hA5, 0);
  endtask

  task automatic pulse_start(input int inst);
    @(posedge clk); #2;
    start[inst] = 1'b1;
    @(posedge clk); #2;
    start[inst] = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({nm, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_bar = 1'b0;
    @(posedge clk); #2;
    rst_bar = 1'b1;
  endtask

  function automatic logic [43:0] pins(input int k);
    return {addr_w[k], rom_ce_bar[k], rom_oe_bar[k], ram_ce_bar[k], ram_we_bar[k],
            dout[k], data_oe[k], busy[k], done[k], error[k], err_addr[k]};
  endfunction

  localparam logic [43:0] PinsRst = {12'h000, 4'b1111, 8'h00, 4'b0000, 12'h000};

  initial begin
    fork
      begin : monitor
        int   ncnt;
        logic prev_we [NI];
        logic prev_done [NI];
        logic prev_err [NI];
        int   we_len [NI];
        ev_t  obs, e;
        ncnt = 0;
        for (int k = 0; k < NI; k++) begin
          prev_we[k] = 1'b1; prev_done[k] = 1'b0; prev_err[k] = 1'b0;
          we_len[k] = 0; start_n[k] = 0;
        end
        forever begin
          @(negedge clk);
          ncnt++;
          for (int k = 0; k < NI; k++) begin
            obs = '0;
            obs.inst = 2'(k);
            if (start[k] && !busy[k] && !done[k] && !error[k]) start_n[k] = ncnt;
            if (data_oe[k] && !rom_oe_bar[k]) chk("contention", 64'd1, 64'd0);
            if (!ram_ce_bar[k] && !ram_we_bar[k]) begin
              ram[k][addr_w[k][3:0]] = dout[k];
              we_len[k]++;
            end
            if (ram_we_bar[k] && !prev_we[k]) begin
              chk("we_len", 64'(we_len[k]), 64'(WEP[k]));
              we_len[k] = 0;
            end
            obs.kind = 2'd3;
            if (!ram_we_bar[k] && prev_we[k]) begin
              obs.kind = 2'd0; obs.addr = addr_w[k]; obs.data = dout[k];
            end else if (done[k] && !prev_done[k]) begin
              obs.kind = 2'd1; obs.cyc = 16'(ncnt - start_n[k] - 1);
            end else if (error[k] && !prev_err[k]) begin
              obs.kind = 2'd2; obs.addr = err_addr[k]; obs.data = {7'd0, done[k]};
            end
            if (obs.kind != 2'd3) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_event", 64'(obs), 64'd0);
              end else begin
                e = exp_q.pop_front();
                chk("event", 64'(obs), 64'(e));
              end
            end
            prev_we[k] = ram_we_bar[k];
            prev_done[k] = done[k];
            prev_err[k] = error[k];
          end
        end
      end
    join_none

    // Reset values, all instances
    #5 rst_bar = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) chk("reset_pins", 64'(pins(k)), 64'(PinsRst));
    @(posedge clk); #2;
    rst_bar = 1'b1;
    repeat (3) @(posedge clk);

    // Copy only: 3 cycles per byte
    push_copy(0, 16);
    push_ev(1, 0, 0, 0, 48);
    pulse_start(0);
    drain("copy_only", 200);
    for (int i = 0; i < 16; i++) chk("ram_image", 64'(ram[0][i]), 64'(i ^ 'hA5));

    // start held high after done: nothing may happen
    @(posedge clk); #2;
    start[0] = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    start[0] = 1'b0;
    chk("done_hold", {62'd0, done[0], busy[0]}, 64'd2);

    // Copy plus verify: 48 + 32 cycles
    push_copy(1, 16);
    push_ev(1, 1, 0, 0, 80);
    pulse_start(1);
    drain("copy_verify", 300);
    chk("verify_err", {63'd0, error[1]}, 64'd0);

    // WE_PULSE=3 with verify: 16*5 + 32 cycles; start pulse while busy ignored
    push_copy(2, 16);
    push_ev(1, 2, 0, 0, 112);
    pulse_start(2);
    repeat (30) @(posedge clk);
    pulse_start(2);
    drain("we3", 400);

    // Stuck RAM bit at address 7
    do_reset();
    stuck = 1'b1;
    push_copy(1, 16);
    push_ev(2, 1, 7, 0, 0);
    pulse_start(1);
    drain("stuck", 300);
    chk("stuck_flags", {62'd0, done[1], error[1]}, 64'd1);
    chk("stuck_err_addr", 64'(err_addr[1]), 64'h007);
    stuck = 1'b0;

    // Reset during the write to address 5, then restart from 0
    do_reset();
    push_copy(0, 5);
    pulse_start(0);
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #2;
        n++;
      end while (!(addr_w[0] == 12'd5 && !ram_we_bar[0]) && n < 100);
      chk("reach_wr5", 64'(n < 100), 64'd1);
    end
    rst_bar = 1'b0;
    #1;
    chk("midcopy_reset_pins", 64'(pins(0)), 64'(PinsRst));
    @(posedge clk); #2;
    rst_bar = 1'b1;
    repeat (10) @(posedge clk);
    chk("aborted_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    push_copy(0, 16);
    push_ev(1, 0, 0, 0, 48);
    pulse_start(0);
    drain("restart", 200);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_copy_seq.md
BOOT_COPY_SEQ -- requirements
Module: boot_copy_seq

Interface
REQ-001 Parameter LAST_ADDR, 12'hFFF, final byte address copied; the start address is always 12'h000.
REQ-002 Parameter WE_PULSE, 1, number of cycles ram_we_bar is held low per byte (range 1..4).
REQ-003 Parameter VERIFY_EN, 1, enables the read-back compare pass after the copy pass.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_bar  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin-copy request; sampled only in IDLE.
REQ-007 addr  output  12  shared address to program store and RAM.
REQ-008 rom_ce_bar, rom_oe_bar  output  1 each  program-store enables (low = active).
REQ-009 ram_ce_bar, ram_we_bar  output  1 each  RAM chip enable and write strobe (low = active).
REQ-010 data_in  input  8  databus value read from the program store or RAM.
REQ-011 data_out  output  8  latched byte driven toward RAM.
REQ-012 data_oe  output  1  high while the block drives the databus.
REQ-013 busy, done, error  output  1 each  sequencer status.
REQ-014 err_addr  output  12  first mismatching address; valid while error=1.

Function
REQ-015 States: IDLE, C_RD, C_WR, C_HOLD, V_ROM, V_RAM, DONE, ERROR.
REQ-016 IDLE: all strobes high, data_oe=0, busy=0; start=1 -> C_RD with addr=0.
REQ-017 C_RD (1 cycle): rom_ce_bar=rom_oe_bar=0; data_in latched into data_out on exit.
REQ-018 C_WR (WE_PULSE cycles): ram_ce_bar=ram_we_bar=0, data_oe=1; addr and data_out are stable.
REQ-019 C_HOLD (1 cycle): ram_we_bar=1, ram_ce_bar=0, data_oe=1 (data hold after the rising edge of WE).
REQ-020 C_HOLD exit: if addr!=LAST_ADDR, increment addr and go to C_RD; else set addr=0 and go to V_ROM if VERIFY_EN, otherwise DONE.
REQ-021 Copy cost is exactly 2+WE_PULSE cycles per byte; addr never wraps past LAST_ADDR.
REQ-022 V_ROM (1 cycle): ROM read; data_in latched into the compare register.
REQ-023 V_RAM (1 cycle): ram_ce_bar=0, ram_we_bar=1, data_oe=0; data_in compared with the compare register.
REQ-024 In V_RAM, a mismatch -> ERROR with err_addr=addr; a match at LAST_ADDR -> DONE; otherwise addr+1 -> V_ROM.
REQ-025 busy=1 in every state except IDLE, DONE and ERROR.
REQ-026 DONE and ERROR are terminal until reset; start is ignored there; strobes are inactive.
REQ-027 done=1 only in DONE, error=1 only in ERROR; they are mutually exclusive.
REQ-028 data_oe and any active ROM strobe are never asserted in the same cycle (no bus contention).
REQ-029 start asserted while busy has no effect.

Reset
REQ-030 rst_bar=0 immediately forces IDLE, addr=0, data_out=0, err_addr=0, all *_bar=1, data_oe=busy=done=error=0.
REQ-031 Reset mid-copy aborts with no further RAM write; a partially written RAM is not repaired.
REQ-032 Release of reset is synchronous to clk; the first state change occurs on the first rising edge of clk with start=1.

Structure
REQ-033 The state encoding and the per-state strobe table live in the shared package hb_boot_pkg.
REQ-034 The 12-bit address counter (clear, increment, terminal-compare) is the sub-module addr_ctr12.
REQ-035 There is no internal tri-state; the top level combines data_out and data_oe onto the databus.

Verification
REQ-036 LAST_ADDR=15, WE_PULSE=1, VERIFY_EN=0, ROM[i]=i^8'hA5; start pulse -> done rises exactly 48 cycles after start is sampled; RAM[i]=i^8'hA5.
REQ-037 Same ROM image with VERIFY_EN=1 -> done after 48+32=80 cycles; error stays 0.
REQ-038 VERIFY_EN=1 with RAM model bit 0 of address 7 stuck -> error=1, err_addr=12'h007, done=0.
REQ-039 WE_PULSE=3 -> ram_we_bar low for exactly 3 consecutive cycles per byte; 5 cycles per byte in total.
REQ-040 rst_bar pulled low during C_WR at addr=5 -> outputs at reset values within the same cycle; no write to address 5 after the reset edge; a new start restarts at addr 0.
REQ-041 start held high continuously after done, and start pulsed while busy -> no state change, no extra writes.
